// File: rtl/demux_rr_dispatcher_if.sv
// ---------------------------------------------------------------------------
// demux_rr_dispatcher_if
//
// This interface bundles the handshake and bus signals of the round-robin
// dispatcher that feeds the 1x4 demultiplexer stage.
//
// Upstream side:
//   in_valid  upstream beat available
//   in_bit    upstream data bit
//   in_ready  dispatcher can accept a beat this cycle
//
// Channel side:
//   ch_mask   per-channel enable (bit k enables channel k)
//   ch_ready  per-channel consumer ready (bit k for channel k)
//   din       registered data bit driven to the demux
//   s1, s0    demux select (target channel)
//   out_valid din/s1/s0 carry a live beat
//   beat_cnt  wrapping count of dispatched beats
//
// Modports:
//   slave   the dispatcher's view of the bus
//   master  the environment's view (upstream source plus channel consumers)
// ---------------------------------------------------------------------------
interface demux_rr_dispatcher_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic [3:0]       ch_mask;
  logic [3:0]       ch_ready;
  logic             din;
  logic             s1;
  logic             s0;
  logic             out_valid;
  logic [CNT_W-1:0] beat_cnt;

  modport slave (
    input  in_valid, in_bit, ch_mask, ch_ready,
    output in_ready, din, s1, s0, out_valid, beat_cnt
  );

  modport master (
    output in_valid, in_bit, ch_mask, ch_ready,
    input  in_ready, din, s1, s0, out_valid, beat_cnt
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_rr_dispatcher
//
// This module is the upstream feeder for the 1x4 demultiplexer stage. It
// accepts single-bit beats over a valid/ready handshake and keeps each beat
// in a one-entry holding register. Each beat gets one of four output
// channels, assigned round-robin and skipping channels that ch_mask
// disables. The registered beat and its target channel drive din/s1/s0.
// They stay stable until the addressed channel raises its ready bit.
//
// Ports:
//   clk  system clock; all state changes on its rising edge
//   rst  synchronous, active-high reset
//   bus  demux_rr_dispatcher_if.slave (handshake, mask/ready, demux outputs,
//        dispatched-beat counter)
//
// Parameters:
//   CNT_W  width of the wrapping dispatched-beat counter
// ---------------------------------------------------------------------------
module demux_rr_dispatcher #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_rr_dispatcher_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             hold_bit_q, hold_bit_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hold_valid;
  logic             fire;
  logic             accept;
  logic             in_ready;
  logic [1:0]       ptr_n;
  logic [1:0]       sel;
  logic [1:0]       cand;

  // A held beat leaves when its latched channel is ready. The mask is not
  // consulted here on purpose: a channel that is masked after the latch
  // still receives the beat it was promised.
  // The search for the next target starts just past the channel that is
  // being served this cycle. This lets a new beat enter in the same cycle
  // that the old one leaves.
  always_comb begin
    hold_valid = (state_q == FULL);
    fire       = hold_valid & bus.ch_ready[target_q];
    ptr_n      = fire ? (target_q + 2'd1) : ptr_q;
    in_ready   = (|bus.ch_mask) & (~hold_valid | fire);
    accept     = bus.in_valid & in_ready;
  end

  // The loop walks from the farthest candidate back to the nearest one.
  // The last enabled channel it assigns is therefore the first enabled
  // channel in round-robin order from ptr_n. When the mask is zero, sel is
  // not used, because in_ready blocks every accept.
  always_comb begin
    sel  = ptr_n;
    cand = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_n + 2'(i);
      if (bus.ch_mask[cand]) begin
        sel = cand;
      end
    end
  end

  // Next-state logic for the EMPTY/FULL holding register.
  // When the register drains, hold_bit and target return to zero. This
  // lets din and {s1,s0} come straight from the flops and still read 0
  // while EMPTY.
  always_comb begin
    state_d    = state_q;
    hold_bit_d = hold_bit_q;
    target_d   = target_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;

    if (fire) begin
      ptr_d = target_q + 2'd1;
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = FULL;
          hold_bit_d = bus.in_bit;
          target_d   = sel;
        end
      end
      FULL: begin
        if (fire && accept) begin
          hold_bit_d = bus.in_bit;
          target_d   = sel;
        end else if (fire) begin
          state_d    = EMPTY;
          hold_bit_d = 1'b0;
          target_d   = 2'd0;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State register. A reset in the middle of a transfer drops the held
  // beat without dispatching it, so beat_cnt does not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      hold_bit_q <= 1'b0;
      target_q   <= 2'd0;
      ptr_q      <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_bit_q <= hold_bit_d;
      target_q   <= target_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = hold_valid;
  assign bus.din       = hold_bit_q;
  assign bus.s1        = target_q[1];
  assign bus.s0        = target_q[0];
  assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_dispatcher
//
// Testbench for demux_rr_dispatcher. A directed sequence covers reset,
// round-robin order, masked-channel skipping, backpressure, mask changes
// while a beat is held, and reset during a transfer. A long randomized run
// follows it.
//
// A behavioural reference model checks every cycle. It tracks the held
// beat as a queue entry, the round-robin pointer as an integer, and the
// beat count modulo 2^CNT_W. Some directed steps also compare against
// constants that follow directly from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_demux_rr_dispatcher;

  localparam int CNT_W   = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  demux_rr_dispatcher_if #(.CNT_W(CNT_W)) bus ();

  demux_rr_dispatcher #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit b;
    int ch;
  } beat_t;

  beat_t held[$];
  int    m_ptr       = 0;
  int    m_cnt       = 0;
  int    vectors     = 0;
  int    miscompares = 0;
  bit    last_accept = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit valid, input bit data,
                               input logic [3:0] mask, input logic [3:0] ready);
    bus.in_valid = valid;
    bus.in_bit   = data;
    bus.ch_mask  = mask;
    bus.ch_ready = ready;
  endtask

  function automatic int pick_channel(input int start, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  // One clock of the reference model. The inputs are already driven while
  // clk is low. This task checks in_ready before the edge and the
  // registered outputs #1 after it, then returns at the next falling edge.
  task automatic step_cycle(input string tag);
    bit    fire;
    bit    exp_rdy;
    bit    acc;
    int    nxt;
    int    exp_sel;
    bit    exp_din;
    beat_t nb;
    fire    = (held.size() != 0) && (bus.ch_ready[held[0].ch] == 1'b1);
    nxt     = fire ? (held[0].ch + 1) % 4 : m_ptr;
    exp_rdy = (bus.ch_mask != 4'b0000) && ((held.size() == 0) || fire);
    acc     = bus.in_valid && exp_rdy && !rst;
    #1;
    if (!rst) checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    last_accept = acc;
    @(posedge clk);
    #1;
    if (rst) begin
      held.delete();
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      if (fire) begin
        void'(held.pop_front());
        m_ptr = nxt;
        m_cnt = (m_cnt + 1) % CNT_MOD;
      end
      if (acc) begin
        nb.b  = bus.in_bit;
        nb.ch = pick_channel(nxt, bus.ch_mask);
        held.push_back(nb);
      end
    end
    exp_sel = (held.size() != 0) ? held[0].ch : 0;
    exp_din = (held.size() != 0) ? held[0].b : 1'b0;
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(held.size() != 0));
    checkOutput({tag, ".din"}, 32'(bus.din), 32'(exp_din));
    checkOutput({tag, ".sel"}, 32'({bus.s1, bus.s0}), 32'(exp_sel));
    checkOutput({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  logic [1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  bit         rr_bits[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] sk_exp [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

  initial begin
    bit          v;
    bit          d;
    logic [3:0]  m;
    logic [3:0]  r;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b1, 4'hF, 4'hF);

    // Reset for two cycles while upstream offers a beat.
    rst = 1'b1;
    step_cycle("reset0");
    step_cycle("reset1");
    checkOutput("reset.out_valid_const", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.beat_cnt_const", 32'(bus.beat_cnt), 32'd0);
    rst = 1'b0;

    // Round-robin over all four channels.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, rr_bits[i], 4'hF, 4'hF);
      step_cycle("rr");
      checkOutput("rr.sel_const", 32'({bus.s1, bus.s0}), 32'(rr_exp[i]));
      checkOutput("rr.din_const", 32'(bus.din), 32'(rr_bits[i]));
    end
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    step_cycle("rr_drain");
    checkOutput("rr.beat_cnt_const", 32'(bus.beat_cnt), 32'd5);

    // Masked channels are skipped.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 4'b1010, 4'hF);
      step_cycle("skip");
      checkOutput("skip.sel_const", 32'({bus.s1, bus.s0}), 32'(sk_exp[i]));
    end
    applyStimulus(1'b0, 1'b0, 4'b1010, 4'hF);
    step_cycle("skip_drain");
    checkOutput("skip.beat_cnt_const", 32'(bus.beat_cnt), 32'd9);

    // Backpressure: hold one beat on channel 2 with all consumers stalled.
    applyStimulus(1'b1, 1'b1, 4'b0100, 4'b0000);
    step_cycle("bp_load");
    checkOutput("bp.sel_load_const", 32'({bus.s1, bus.s0}), 32'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 4'hF, 4'b0000);
      step_cycle("bp_stall");
      checkOutput("bp.sel_frozen_const", 32'({bus.s1, bus.s0}), 32'd2);
    end
    applyStimulus(1'b1, 1'b0, 4'hF, 4'b0100);
    step_cycle("bp_release");
    checkOutput("bp.sel_next_const", 32'({bus.s1, bus.s0}), 32'd3);
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    step_cycle("bp_drain");

    // A mask change does not retarget a beat that is already held.
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0000);
    step_cycle("mc_load");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0001, 4'b0001);
      step_cycle("mc_wait");
      checkOutput("mc.sel_wait_const", 32'({bus.s1, bus.s0}), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0010);
    step_cycle("mc_release");
    checkOutput("mc.sel_next_const", 32'({bus.s1, bus.s0}), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'b0001, 4'hF);
    step_cycle("mc_drain");
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'hF);
    step_cycle("mask_zero");
    checkOutput("mask_zero.out_valid_const", 32'(bus.out_valid), 32'd0);

    // Reset while a beat is held.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'b0000);
    step_cycle("rm_load");
    rst = 1'b1;
    step_cycle("rm_reset");
    checkOutput("rm.out_valid_const", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    step_cycle("rm_after");
    checkOutput("rm.sel_const", 32'({bus.s1, bus.s0}), 32'd0);

    // Random traffic. The long stretch without reset wraps beat_cnt; the
    // final stretch adds occasional resets. Upstream holds its beat until
    // the beat is accepted.
    for (int i = 0; i < 1400; i++) begin
      if (bus.in_valid && !last_accept) begin
        v = 1'b1;
        d = bus.in_bit;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        d = 1'($urandom_range(0, 1));
      end
      m = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      applyStimulus(v, d, m, r);
      rst = (i >= 1200) && ($urandom_range(0, 31) == 0);
      step_cycle("rand");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Upstream feeder for the 1x4 demultiplexer stage. It accepts single-bit beats over a valid/ready handshake and holds each beat in a one-entry register. It assigns each beat round-robin to one of four output channels, skipping channels disabled by a mask. It drives the demux data and select lines (din, s1, s0) and holds them stable until the addressed channel accepts the beat.

Parameters:
CNT_W, 8, width of the wrapping dispatched-beat counter.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream beat available
in_bit  input  1  upstream data bit
in_ready  output  1  dispatcher can accept a beat this cycle
ch_mask  input  4  per-channel enable; bit k enables channel k
ch_ready  input  4  per-channel consumer ready; bit k for channel k
din  output  1  data to demux (registered beat)
s1  output  1  demux select MSB (target channel bit 1)
s0  output  1  demux select LSB (target channel bit 0)
out_valid  output  1  din/s1/s0 carry a live beat
beat_cnt  output  CNT_W  total beats dispatched, wraps modulo 2^CNT_W

Behaviour:
- Reset values (synchronous, rst high at a clk edge): hold_valid=0, ptr=0, target=0, din=0, s1=0, s0=0, out_valid=0, beat_cnt=0. Reset mid-transfer drops the held beat silently. beat_cnt does not increment in the reset cycle.
- State: hold_valid, hold_bit, target[1:0], ptr[1:0]. Two states:
  - EMPTY (hold_valid=0)
  - FULL (hold_valid=1)
- Outputs:
  - out_valid = hold_valid.
  - din = hold_bit when FULL, else 0.
  - {s1,s0} = target when FULL, else 2'b00.
  - All outputs are driven directly from registers.
- fire = hold_valid & ch_ready[target].
- Next pointer: ptr_n = target+1 (mod 4) if fire, else ptr.
- Channel search: sel = first k in order ptr_n, ptr_n+1, ptr_n+2, ptr_n+3 (mod 4) with ch_mask[k]=1.
- in_ready = (|ch_mask) & (~hold_valid | fire). This is combinational from ch_ready and ch_mask, by design: one beat per cycle at full throughput.
- accept = in_valid & in_ready.
- Transitions:
  - EMPTY & accept -> FULL: hold_bit<=in_bit, target<=sel.
  - FULL & fire & accept -> FULL: new beat loaded, target<=sel computed from ptr_n.
  - FULL & fire & ~accept -> EMPTY.
  - FULL & ~fire -> FULL: din/s1/s0 stable.
- On fire: ptr<=target+1 (mod 4), beat_cnt<=beat_cnt+1 (wraps to 0 at 2^CNT_W-1).
- Mask rules:
  - Target is latched at accept. Later ch_mask changes do not retarget a held beat; it waits for ch_ready[target] even if that channel is now masked.
  - ch_mask=0: in_ready=0, no beats accepted; a held beat still dispatches normally.
- Single enabled channel: every beat goes to that channel.
- in_bit is ignored when accept=0. Upstream must hold in_valid/in_bit until accepted.
- Latency: beat accepted at edge N appears on din/s1/s0 with out_valid=1 after edge N. It is consumed at the first later edge where ch_ready[target]=1.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, din=0, {s1,s0}=00, beat_cnt=0, nothing accepted.
- Round-robin: ch_mask=4'b1111, ch_ready=4'b1111, in_valid=1, in_bit stream 1,0,1,1,0 -> {s1,s0} sequence 00,01,10,11,00 on consecutive cycles; din follows the bits; beat_cnt=5; in_ready stays 1.
- Skip masked: ch_mask=4'b1010, all ready, 4 beats -> targets 01,11,01,11.
- Backpressure: ch_ready=4'b0000 with one beat held on channel 2 -> din/s1/s0 frozen, in_ready=0 for 5 cycles. Raise ch_ready[2] -> fire on that edge; next beat accepted in the same cycle, targeting channel 3.
- Mask change while held: beat latched to channel 1, then ch_mask<=4'b0001 -> beat still waits for and goes to channel 1; next beat goes to channel 0. ch_mask=0 with hold empty -> in_ready=0.
- Wrap/reset mid-op: CNT_W=2, dispatch 5 beats -> beat_cnt reads 1. Assert rst while FULL -> out_valid=0 on next edge; next beat targets channel 0.
